// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Pure declarations: no timing, no flow control.
package fetch_pkg;

   localparam logic [31:0] RV32I_NOP        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fetch_occ_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries; push is visible at the head the cycle after (no bypass).
// Backpressure: the caller never pushes when FULL; flush empties it in one cycle.
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_dat,
   input  logic         pop,
   output logic         head_vld,
   output fetch_entry_t head_dat,
   output fetch_occ_t   count
);

   fetch_entry_t entry0_q, entry0_d;
   fetch_entry_t entry1_q, entry1_d;
   fetch_occ_t   count_q, count_d;

   // entry0 is always the head, so a pop from FULL shifts entry1 forward
   always_comb begin
      entry0_d = entry0_q;
      entry1_d = entry1_q;
      count_d  = count_q;
      if (flush) begin
         count_d = EMPTY;
      end else begin
         case (count_q)
            EMPTY: begin
               if (push) begin
                  entry0_d = push_dat;
                  count_d  = ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  entry0_d = push_dat;
               end else if (push) begin
                  entry1_d = push_dat;
                  count_d  = FULL;
               end else if (pop) begin
                  count_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  entry0_d = entry1_q;
                  count_d  = ONE;
               end
            end
            default: count_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= EMPTY;
      end else begin
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
   end

   assert property (@(posedge clk) disable iff (reset) !(push && !flush && count_q == FULL));

   assign head_vld = (count_q != EMPTY);
   assign head_dat = entry0_q;
   assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC; first instruction valid 3 cycles after reset/redirect, then 1/cycle.
// Decoder stalls park the in-flight word in the 2-entry buffer and stop issue; FETCH_PERF_EN adds perf counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_data_out,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`endif
);

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  pending_pc_q, pending_pc_d;
   logic         pending_q, pending_d;
   logic         pop, push, issue;
   logic [2:0]   occ_after;
   logic         head_vld;
   fetch_entry_t head_dat, push_dat;
   fetch_occ_t   count;
   logic         unused_rpc_lsb;

   assign unused_rpc_lsb = ^redirect_pc[1:0];

   assign pop       = head_vld & instr_ready;
   // Occupancy once this cycle's pop and the outstanding response settle; issue only if one slot stays free
   assign occ_after = {1'b0, count} + {2'b00, pending_q} - {2'b00, pop};
   assign issue     = !redirect_valid && !reset && (occ_after <= 3'd1);
   assign push      = pending_q & ~redirect_valid;
   assign push_dat  = '{pc: pending_pc_q, instr: imem_data_out};

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      pending_pc_d = pending_pc_q;
      pending_d    = issue;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end else if (issue) begin
         pending_pc_d = fetch_pc_q;
         fetch_pc_d   = fetch_pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         pending_pc_q <= RESET_PC;
         pending_q    <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         pending_pc_q <= pending_pc_d;
         pending_q    <= pending_d;
      end
   end

   fetch_buffer u_buffer (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect_valid),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head_vld (head_vld),
      .head_dat (head_dat),
      .count    (count)
   );

   assign imem_address = fetch_pc_q;
   assign instr_valid  = head_vld;
   assign instr        = head_vld ? head_dat.instr : RV32I_NOP;
   assign instr_pc     = head_vld ? head_dat.pc : 32'd0;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_bubbles_q, perf_bubbles_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + {31'd0, pop};
      perf_bubbles_d = perf_bubbles_q + {31'd0, ~head_vld};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_q <= 32'd0;
         perf_bubbles_q <= 32'd0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_bubbles_q <= perf_bubbles_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
